// File: rtl/uart_rx_fifo_if.sv
// CPU-side read/status interface of the UART receiver FIFO.
// The slave modport is the receiver; the master modport is the CPU I/O decoder.
// With UART_RX_PARITY_EN defined the interface also carries parity_err.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                                 rd_en;
    logic [7:0]                           rd_data;
    logic                                 rd_valid;
    logic [$clog2(FIFO_DEPTH + 1) - 1:0]  count;
    logic                                 frame_err;
    logic                                 overrun;
    logic                                 clear_err;
`ifdef UART_RX_PARITY_EN
    logic                                 parity_err;
`endif

    modport master (
        output rd_en, clear_err,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rd_data, rd_valid, count, frame_err, overrun
    );

    modport slave (
        input  rd_en, clear_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rd_data, rd_valid, count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, oversampling 8N1 deserialiser (LSB first),
// show-ahead receive FIFO and sticky frame/overrun status.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing and adds parity_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx,
    uart_rx_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RECOVER
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_q;
    logic               push_req;
    logic               frame_err_q;
    logic               overrun_q;
`ifdef UART_RX_PARITY_EN
    logic               par_bad;
    logic               parity_err_q;
`endif

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CW-1:0]      count_q;
    logic               full;
    logic               do_pop;
    logic               do_push;
    logic               drop;

    // Bring the asynchronous line into the clock domain; idle-high after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame state machine: start validation, bit sampling, stop check and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            push_req    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            // Clear first so a coinciding set event below takes priority.
            if (bus.clear_err) begin
                frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        // Even parity: data bits plus parity bit must XOR to zero.
                        par_bad  <= ^{shift_q, rx_s};
                        if (^{shift_q, rx_s}) begin
                            parity_err_q <= 1'b1;
                        end
                        state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            push_req <= !par_bad;
`else
                            push_req <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= RECOVER;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    // Wait for the line to return high so a break is not read as start bits.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift register holds only data; it is overwritten before every use so needs no reset.
    always_ff @(posedge clock) begin
        if (state == DATA && baud_cnt == BIT_LAST) begin
            shift_q <= {rx_s, shift_q[7:1]};
        end
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = bus.rd_en && (count_q != '0);
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && full && !do_pop;

    // FIFO pointers, occupancy and the overrun flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.clear_err) begin
                overrun_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // FIFO storage write; the byte comes straight from the shift register.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    assign bus.rd_valid  = (count_q != '0);
    assign bus.rd_data   = (count_q != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.count     = count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Expected values come from a queue-based model of frames, FIFO and sticky flags.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] q[$];
    bit m_fe = 1'b0;
    bit m_ov = 1'b0;
`ifdef UART_RX_PARITY_EN
    bit m_pe = 1'b0;
`endif

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Start bit, eight data bits LSB first, and the parity bit when framing is 8E1.
    task automatic drive_head(input logic [7:0] b, input bit par_flip);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        if (HAS_PAR) begin
            rx = (^b) ^ par_flip;
            cyc(CPB);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input bit par_flip);
        drive_head(b, par_flip);
        rx = stop;
        cyc(CPB);
        rx = 1'b1;
    endtask

    // Model of one received frame: good bytes enter if room, otherwise overrun.
    function automatic void model_frame(input logic [7:0] b, input bit stop, input bit par_ok,
                                        input bit pop_same);
`ifdef UART_RX_PARITY_EN
        if (!par_ok) m_pe = 1'b1;
`endif
        if (!stop) m_fe = 1'b1;
        if (stop && par_ok) begin
            if (pop_same && q.size() > 0) q.delete(0);
            if (q.size() < DEPTH) q.push_back(b);
            else m_ov = 1'b1;
        end
    endfunction

    task automatic pop_once();
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        if (q.size() > 0) q.delete(0);
    endtask

    function automatic logic [7:0] model_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        reset = 1'b0;
        cyc(4);
    endtask

    task automatic test_single();
        drive_head(8'hA5, 1'b0);
        rx = 1'b1;
        cyc(11);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_early got rd_valid=%b want 0", bus.rd_valid); end
        cyc(1);
        model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.rd_valid); end
        checks++; if (bus.rd_data !== model_head()) begin errors++; $display("FAIL single_data got %h want %h", bus.rd_data, model_head()); end
        checks++; if (bus.count !== 3'(q.size())) begin errors++; $display("FAIL single_count got %0d want %0d", bus.count, q.size()); end
        cyc(4);
        pop_once();
        checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL single_pop got valid=%b count=%0d want 0/0", bus.rd_valid, bus.count); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL single_empty_data got %h want 00", bus.rd_data); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        cyc(30);
        checks++; if (bus.count !== 3'd0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL glitch got count=%0d frame_err=%b want 0/0", bus.count, bus.frame_err); end
        drive_frame(8'h96, 1'b1, 1'b0);
        model_frame(8'h96, 1'b1, 1'b1, 1'b0);
        cyc(2);
        checks++; if (bus.rd_data !== model_head() || bus.count !== 3'(q.size())) begin errors++; $display("FAIL glitch_next got %h/%0d want %h/%0d", bus.rd_data, bus.count, model_head(), q.size()); end
        pop_once();
    endtask

    task automatic test_frame_err();
        drive_head(8'h3C, 1'b0);
        rx = 1'b0;
        cyc(CPB + 40);
        rx = 1'b1;
        model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        cyc(4);
        checks++; if (bus.frame_err !== m_fe || bus.count !== 3'(q.size())) begin errors++; $display("FAIL frame_err got fe=%b count=%0d want %b/%0d", bus.frame_err, bus.count, m_fe, q.size()); end
        drive_frame(8'h5A, 1'b1, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        cyc(2);
        checks++; if (bus.count !== 3'(q.size()) || bus.rd_data !== model_head()) begin errors++; $display("FAIL frame_next got %0d/%h want %0d/%h", bus.count, bus.rd_data, q.size(), model_head()); end
        checks++; if (bus.frame_err !== m_fe) begin errors++; $display("FAIL frame_sticky got %b want %b", bus.frame_err, m_fe); end
        bus.clear_err = 1'b1;
        cyc(1);
        bus.clear_err = 1'b0;
        m_fe = 1'b0;
        checks++; if (bus.frame_err !== m_fe) begin errors++; $display("FAIL frame_clear got %b want %b", bus.frame_err, m_fe); end
        pop_once();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            drive_frame(8'(i), 1'b1, 1'b0);
            model_frame(8'(i), 1'b1, 1'b1, 1'b0);
            cyc(2);
        end
        checks++; if (bus.count !== 3'(q.size()) || bus.overrun !== m_ov) begin errors++; $display("FAIL ovr_full got count=%0d ovr=%b want %0d/%b", bus.count, bus.overrun, q.size(), m_ov); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rd_data !== model_head() || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL ovr_pop%0d got %h want %h", i, bus.rd_data, model_head()); end
            pop_once();
        end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty got %b want 0", bus.rd_valid); end
        pop_once();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL ovr_empty_pop got count=%0d want 0", bus.count); end
        bus.clear_err = 1'b1;
        cyc(1);
        bus.clear_err = 1'b0;
        m_ov = 1'b0;
        checks++; if (bus.overrun !== m_ov) begin errors++; $display("FAIL ovr_clear got %b want %b", bus.overrun, m_ov); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            drive_frame(8'h10 + 8'(i), 1'b1, 1'b0);
            model_frame(8'h10 + 8'(i), 1'b1, 1'b1, 1'b0);
            cyc(2);
        end
        drive_head(8'h14, 1'b0);
        rx = 1'b1;
        cyc(11);
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        model_frame(8'h14, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.count !== 3'(q.size()) || bus.overrun !== m_ov) begin errors++; $display("FAIL fpp_count got %0d/%b want %0d/%b", bus.count, bus.overrun, q.size(), m_ov); end
        cyc(4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rd_data !== model_head()) begin errors++; $display("FAIL fpp_pop%0d got %h want %h", i, bus.rd_data, model_head()); end
            pop_once();
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        drive_frame(8'h03, 1'b1, 1'b1);
        model_frame(8'h03, 1'b1, 1'b0, 1'b0);
        cyc(4);
        checks++; if (bus.parity_err !== m_pe || bus.count !== 3'(q.size())) begin errors++; $display("FAIL parity got pe=%b count=%0d want %b/%0d", bus.parity_err, bus.count, m_pe, q.size()); end
        bus.clear_err = 1'b1;
        cyc(1);
        bus.clear_err = 1'b0;
        m_pe = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        checks++; if (bus.parity_err !== m_pe) begin errors++; $display("FAIL parity_clear got %b want %b", bus.parity_err, m_pe); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            bit stop;
            int npop;
            b = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            drive_frame(b, stop, 1'b0);
            model_frame(b, stop, 1'b1, 1'b0);
            cyc(4);
            checks++; if (bus.count !== 3'(q.size()) || bus.rd_data !== model_head()) begin errors++; $display("FAIL rnd%0d_fifo got %0d/%h want %0d/%h", n, bus.count, bus.rd_data, q.size(), model_head()); end
            checks++; if (bus.frame_err !== m_fe || bus.overrun !== m_ov) begin errors++; $display("FAIL rnd%0d_flags got fe=%b ov=%b want %b/%b", n, bus.frame_err, bus.overrun, m_fe, m_ov); end
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                pop_once();
                checks++; if (bus.rd_data !== model_head()) begin errors++; $display("FAIL rnd%0d_pop got %h want %h", n, bus.rd_data, model_head()); end
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.clear_err = 1'b1;
                cyc(1);
                bus.clear_err = 1'b0;
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_frame(8'h42, 1'b1, 1'b0);
        model_frame(8'h42, 1'b1, 1'b1, 1'b0);
        drive_frame(8'h00, 1'b0, 1'b0);
        model_frame(8'h00, 1'b0, 1'b1, 1'b0);
        cyc(4);
        rx = 1'b0;
        cyc(CPB);
        rx = 1'b1;
        cyc(CPB * 3 + CPB / 2);
        reset = 1'b1;
        cyc(1);
        q.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_fifo got %b/%0d/%h want 0/0/00", bus.rd_valid, bus.count, bus.rd_data); end
        checks++; if (bus.frame_err !== m_fe || bus.overrun !== m_ov) begin errors++; $display("FAIL rstmid_flags got %b/%b want %b/%b", bus.frame_err, bus.overrun, m_fe, m_ov); end
        reset = 1'b0;
        cyc(CPB * 6);
        drive_frame(8'h7E, 1'b1, 1'b0);
        model_frame(8'h7E, 1'b1, 1'b1, 1'b0);
        cyc(2);
        checks++; if (bus.rd_data !== model_head() || bus.count !== 3'(q.size())) begin errors++; $display("FAIL rstmid_next got %h/%0d want %h/%0d", bus.rd_data, bus.count, model_head(), q.size()); end
    endtask

    initial begin
        bus.rd_en = 1'b0;
        bus.clear_err = 1'b0;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end that feeds the memory-mapped CPU system from its `rx` pin.
- Synchronises and oversamples the asynchronous 8N1 line, then deserialises bytes LSB-first.
- Pushes good bytes into a small show-ahead FIFO that the CPU I/O decoder pops.
- Flags framing errors and overruns as sticky status bits for software polling.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per bit (50 MHz / 9600 baud); minimum 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line, idle high.
- rd_en  input  1  pop head entry this cycle.
- rd_data  output  8  FIFO head byte (show-ahead); 8'h00 when empty.
- rd_valid  output  1  FIFO not empty.
- count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: good byte dropped because FIFO was full.
- clear_err  input  1  clears frame_err and overrun.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - Outputs: rd_data=0, rd_valid=0, count=0, frame_err=0, overrun=0.
  - Internal: state=IDLE, synchroniser flops=1, FIFO pointers=0.
- rx passes through a 2-flop synchroniser, giving rx_s; all decisions use rx_s.
- State machine (IDLE, START, DATA, STOP, RECOVER):
  - IDLE:
    - Enter START when rx_s=0; the baud counter loads with 0.
  - START:
    - At counter = CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s.
    - If 0: go to DATA with the counter reset.
    - If 1: glitch; return to IDLE with no status change.
  - DATA:
    - Sample rx_s every CLKS_PER_BIT clocks; shift into bit index 0..7, LSB first.
    - After bit 7, go to STOP.
  - STOP:
    - Sample after CLKS_PER_BIT clocks.
    - If 1: push the byte (see overrun rules below), then go to IDLE.
    - If 0: set frame_err, discard the byte, go to RECOVER.
  - RECOVER:
    - Stay until rx_s=1, then go to IDLE. This prevents a break condition being treated as a stream of start bits.
- Latency: a pushed byte is visible on rd_data/rd_valid on the clock edge after the stop-bit sample, i.e. one cycle after the push decision.
- FIFO:
  - Circular buffer with wrap-around pointers; count tracks occupancy.
  - Pop with rd_en=1 when empty: ignored, no pointer or count change.
  - Push when full with no pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle when full: both accepted; count stays FIFO_DEPTH; overrun not set.
  - Push and pop in the same cycle when empty: push accepted, pop ignored; count becomes 1.
  - Push and pop in the same cycle otherwise: both accepted; count unchanged.
- Sticky flags:
  - clear_err=1 clears both flags on that edge.
  - If a set event coincides with clear_err, the set wins.
- Reset mid-frame: the partial byte is discarded, the FIFO is emptied, and the state returns to IDLE. If the line is still low after reset, this is treated as a start bit.

Optional Feature:
- UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1: an even-parity bit is sampled one bit-time after bit 7, before STOP.
  - Adds output port `parity_err` (1 bit, sticky, reset 0, cleared by clear_err).
  - On parity mismatch the byte is discarded and parity_err is set. The stop bit is still checked and can also set frame_err.
- Undefined: 8N1 only; no parity state and no parity_err port.

Test Plan:
- Bench configuration: CLKS_PER_BIT=16, FIFO_DEPTH=4.
- Single byte: send 8'hA5 with a valid stop bit → rd_valid=1, rd_data=8'hA5, count=1 one cycle after stop sample; rd_en pulse → rd_valid=0, count=0.
- Glitch rejection: drive rx low for 4 clocks, then high → state returns to IDLE; count=0; frame_err=0.
- Framing error: send 8'h3C with stop bit 0, rx held low for 40 clocks, then send 8'h5A → frame_err=1; only 8'h5A enters the FIFO; count=1.
- Full and overrun:
  - Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no pops → count=4, overrun=1.
  - Pops return 01, 02, 03, 04, then rd_valid=0.
  - clear_err → overrun=0.
- Full simultaneous push and pop: with the FIFO full of 10..13, assert rd_en on the push cycle of 8'h14 → count stays 4, overrun=0, read order 11, 12, 13, 14.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hFF → all outputs at reset values; the next byte 8'h7E is received correctly.
- With UART_RX_PARITY_EN: 8'h03 with parity bit 1 → parity_err=1, byte dropped.
